// File: rtl/tri_fetch_stream.sv
// tri_fetch_stream: walks a facet range of an indexed mesh and streams one
// homogeneous triangle per facet to the transform stage.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   start_in                  run request (first_facet_in, facet_count_in)
//   facet_addr_out/_data_in   facet ROM: address out, {f1,f2,f3} back
//   vertex_addr_out/_data_in  vertex ROM: address out, {x,y,z} back
//   tri_out, valid_out, ready_in  triangle stream (v0 in the LSBs)
//   busy_out, obj_done_out, err_out  run status, end pulse, sticky bad index
module tri_fetch_stream #(
    parameter int NUM_FACETS   = 12,
    parameter int NUM_VERTICES = 8,
    parameter int COORD_WIDTH  = 32,
    parameter int IDX_WIDTH    = 16,
    parameter int ROM_LATENCY  = 2,
    parameter logic [COORD_WIDTH-1:0] W_ONE = COORD_WIDTH'(32'h0001_0000)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [IDX_WIDTH-1:0]      first_facet_in,
    input  logic [IDX_WIDTH-1:0]      facet_count_in,
    output logic [IDX_WIDTH-1:0]      facet_addr_out,
    input  logic [3*IDX_WIDTH-1:0]    facet_data_in,
    output logic [IDX_WIDTH-1:0]      vertex_addr_out,
    input  logic [3*COORD_WIDTH-1:0]  vertex_data_in,
    output logic [12*COORD_WIDTH-1:0] tri_out,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic                      busy_out,
    output logic                      obj_done_out,
    output logic                      err_out
);
    localparam int WW = $clog2(ROM_LATENCY + 1);
    localparam int VW = 4 * COORD_WIDTH;
    localparam logic [WW-1:0]        LAT    = WW'(ROM_LATENCY);
    localparam logic [IDX_WIDTH-1:0] NV     = IDX_WIDTH'(NUM_VERTICES);
    localparam logic [IDX_WIDTH-1:0] F_LAST = IDX_WIDTH'(NUM_FACETS - 1);
    localparam logic [IDX_WIDTH-1:0] ONE    = IDX_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_F, S_FETCH_V0, S_FETCH_V1, S_FETCH_V2, S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [WW-1:0]             wait_q, wait_d;
    logic [IDX_WIDTH-1:0]      facet_addr_q, facet_addr_d;
    logic [IDX_WIDTH-1:0]      remain_q, remain_d;
    logic [IDX_WIDTH-1:0]      vertex_addr_q, vertex_addr_d;
    logic [IDX_WIDTH-1:0]      f2_q, f2_d;
    logic [IDX_WIDTH-1:0]      f3_q, f3_d;
    logic [12*COORD_WIDTH-1:0] tri_q, tri_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    // Vertex being captured; an out-of-range index never trusts ROM data.
    logic          bad_idx;
    logic [VW-1:0] vtx;

    always_comb begin
        bad_idx = (vertex_addr_q >= NV);
        vtx = bad_idx ? {{(3*COORD_WIDTH){1'b0}}, W_ONE}
                      : {vertex_data_in, W_ONE};
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        facet_addr_d  = facet_addr_q;
        remain_d      = remain_q;
        vertex_addr_d = vertex_addr_q;
        f2_d          = f2_q;
        f3_d          = f3_q;
        tri_d         = tri_q;
        valid_d       = valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (facet_count_in != '0) begin
                        facet_addr_d = first_facet_in;
                        remain_d     = facet_count_in;
                        busy_d       = 1'b1;
                        wait_d       = LAT;
                        state_d      = S_FETCH_F;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH_F: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    vertex_addr_d = facet_data_in[3*IDX_WIDTH-1 -: IDX_WIDTH];
                    f2_d          = facet_data_in[2*IDX_WIDTH-1 -: IDX_WIDTH];
                    f3_d          = facet_data_in[IDX_WIDTH-1:0];
                    wait_d        = LAT;
                    state_d       = S_FETCH_V0;
                end
            end
            S_FETCH_V0, S_FETCH_V1, S_FETCH_V2: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    err_d  = err_q | bad_idx;
                    wait_d = LAT;
                    if (state_q == S_FETCH_V0) begin
                        tri_d[0 +: VW] = vtx;
                        vertex_addr_d  = f2_q;
                        state_d        = S_FETCH_V1;
                    end else if (state_q == S_FETCH_V1) begin
                        tri_d[VW +: VW] = vtx;
                        vertex_addr_d   = f3_q;
                        state_d         = S_FETCH_V2;
                    end else begin
                        tri_d[2*VW +: VW] = vtx;
                        valid_d           = 1'b1;
                        state_d           = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    if (remain_q == ONE) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        remain_d     = remain_q - 1'b1;
                        facet_addr_d = (facet_addr_q >= F_LAST) ? '0
                                       : facet_addr_q + 1'b1;
                        wait_d       = LAT;
                        state_d      = S_FETCH_F;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            facet_addr_q  <= '0;
            remain_q      <= '0;
            vertex_addr_q <= '0;
            f2_q          <= '0;
            f3_q          <= '0;
            tri_q         <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            facet_addr_q  <= facet_addr_d;
            remain_q      <= remain_d;
            vertex_addr_q <= vertex_addr_d;
            f2_q          <= f2_d;
            f3_q          <= f3_d;
            tri_q         <= tri_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign facet_addr_out  = facet_addr_q;
    assign vertex_addr_out = vertex_addr_q;
    assign tri_out         = tri_q;
    assign valid_out       = valid_q;
    assign busy_out        = busy_q;
    assign obj_done_out    = done_q;
    assign err_out         = err_q;
endmodule

// File: tb/tb_tri_fetch_stream.sv
// tb_tri_fetch_stream: cube mesh in behavioural ROMs, queue-based model of
// the expected triangle stream, directed runs with literal pins.
module tb_tri_fetch_stream;
    localparam int L  = 2;
    localparam int NF = 12;
    localparam int NV = 8;
    localparam logic [31:0] W1 = 32'h0001_0000;

    logic         clk = 1'b0;
    logic         rst_in = 1'b1;
    logic         start_in = 1'b0;
    logic         ready_in = 1'b0;
    logic [15:0]  first_facet_in = '0;
    logic [15:0]  facet_count_in = '0;
    logic [15:0]  facet_addr_out, vertex_addr_out;
    logic [47:0]  facet_data_in;
    logic [95:0]  vertex_data_in;
    logic [383:0] tri_out;
    logic         valid_out, busy_out, obj_done_out, err_out;

    always #5 clk = ~clk;

    tri_fetch_stream dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
        .first_facet_in(first_facet_in), .facet_count_in(facet_count_in),
        .facet_addr_out(facet_addr_out), .facet_data_in(facet_data_in),
        .vertex_addr_out(vertex_addr_out), .vertex_data_in(vertex_data_in),
        .tri_out(tri_out), .valid_out(valid_out), .ready_in(ready_in),
        .busy_out(busy_out), .obj_done_out(obj_done_out), .err_out(err_out)
    );

    // Cube: 12 facets over 8 vertices.
    int fr[36] = '{0,1,2, 0,2,3, 4,6,5, 4,7,6, 0,4,5, 0,5,1,
                   1,5,6, 1,6,2, 2,6,7, 2,7,3, 3,7,4, 3,4,0};

    function automatic logic [31:0] vx(input int i);
        return 32'h100 + 32'(i);
    endfunction
    function automatic logic [31:0] vy(input int i);
        return 32'h200 + 32'(i);
    endfunction
    function automatic logic [31:0] vz(input int i);
        return 32'h300 + 32'(i);
    endfunction

    // ROMs with L cycles of latency.
    int cyc = 0;
    logic [15:0] fh[L] = '{default: 16'h0};
    logic [15:0] vh[L] = '{default: 16'h0};
    always @(posedge clk) begin
        cyc <= cyc + 1;
        fh[0] <= facet_addr_out;
        vh[0] <= vertex_addr_out;
        for (int i = 1; i < L; i++) begin
            fh[i] <= fh[i-1];
            vh[i] <= vh[i-1];
        end
    end

    always_comb begin
        facet_data_in  = 48'hBAD0_BAD1_BAD2;
        vertex_data_in = {3{32'hDEAD_BEEF}};
        if (int'(fh[L-1]) < NF)
            facet_data_in = {16'(fr[int'(fh[L-1])*3]),
                             16'(fr[int'(fh[L-1])*3+1]),
                             16'(fr[int'(fh[L-1])*3+2])};
        if (int'(vh[L-1]) < NV)
            vertex_data_in = {vx(int'(vh[L-1])), vy(int'(vh[L-1])),
                              vz(int'(vh[L-1]))};
    end

    function automatic logic [383:0] model_tri(input int fa);
        logic [383:0] t;
        int idx;
        t = '0;
        for (int v = 0; v < 3; v++) begin
            idx = fr[fa*3+v];
            if (idx >= NV) t[v*128 +: 128] = {96'h0, W1};
            else t[v*128 +: 128] = {vx(idx), vy(idx), vz(idx), W1};
        end
        return t;
    endfunction

    typedef struct {
        logic [383:0] t;
        logic [15:0]  fa;
        logic         err;
    } exp_t;

    exp_t   expq[$];
    int     hs_fa[$];
    int     n_vec = 0;
    int     n_err = 0;
    logic   err_model = 1'b0;
    int     done_cnt = 0, done_cyc = 0, start_cyc = 0;
    int     last_hs = 0, run_hs = 0;
    logic   done_busy = 1'b0;
    bit     timing_chk = 1'b0;
    logic [383:0] first_tri = '0;
    logic [383:0] ptri = '0;
    logic   pv = 1'b0, phs = 1'b0;

    task automatic chk(input string name, input logic [383:0] act,
                       input logic [383:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: stability under stall, every accepted triangle.
    always @(negedge clk) begin
        if (rst_in) begin
            pv  = 1'b0;
            phs = 1'b0;
        end else begin
            if (valid_out && pv && !phs) chk("hold_tri", tri_out, ptri);
            if (valid_out && ready_in) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_tri: got facet %0d expected none",
                             facet_addr_out);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("tri", tri_out, e.t);
                    chk("facet_addr", 384'(facet_addr_out), 384'(e.fa));
                    chk("err_flag", 384'(err_out), 384'(e.err));
                end
                if (timing_chk) begin
                    if (run_hs == 0) chk("first_latency", cyc - start_cyc, 13);
                    else chk("spacing", cyc - last_hs, 13);
                end
                if (run_hs == 0) first_tri = tri_out;
                run_hs++;
                last_hs = cyc;
                hs_fa.push_back(int'(facet_addr_out));
            end
            if (obj_done_out) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy_out;
            end
            pv   = valid_out;
            ptri = tri_out;
            phs  = valid_out && ready_in;
        end
    end

    task automatic run(input int first, input int count, input int stall,
                       input bit timing, input int extra);
        int budget, vcnt, k, d0, fa;
        for (int i = 0; i < count; i++) begin
            fa = (first + i) % NF;
            for (int v = 0; v < 3; v++)
                if (fr[fa*3+v] >= NV) err_model = 1'b1;
            expq.push_back('{model_tri(fa), 16'(fa), err_model});
        end
        d0 = done_cnt;
        run_hs = 0;
        hs_fa.delete();
        timing_chk = timing;
        ready_in = (stall == 0);
        @(posedge clk); #1;
        start_in = 1'b1;
        first_facet_in = 16'(first);
        facet_count_in = 16'(count);
        start_cyc = cyc;
        @(posedge clk); #1;
        start_in = 1'b0;
        budget = count * (16 + stall) + 30;
        vcnt = 0;
        k = 1;
        while (done_cnt == d0 && budget > 0) begin
            if (extra != 0 && k == extra) begin
                start_in = 1'b1;
                first_facet_in = 16'd7;
                facet_count_in = 16'd5;
            end else begin
                start_in = 1'b0;
            end
            if (valid_out && !ready_in) begin
                if (vcnt == stall) ready_in = 1'b1;
                else vcnt++;
            end
            @(posedge clk); #1;
            budget--;
            k++;
        end
        start_in = 1'b0;
        ready_in = 1'b1;
        if (budget == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: got no obj_done expected one");
        end
        chk("leftover_expected", 384'(expq.size()), 0);
        expq.delete();
        chk("handshakes", 384'(run_hs), 384'(count));
        chk("busy_at_done", 384'(done_busy), 0);
        if (count == 0) chk("done_latency", done_cyc - start_cyc, 1);
        else chk("done_after_hs", done_cyc - last_hs, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("single_done", 384'(done_cnt), 384'(d0 + 1));
        timing_chk = 1'b0;
    endtask

    initial begin
        int wl[4] = '{10, 11, 0, 1};
        int d0;
        rst_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tri", tri_out, 0);
        chk("reset_flags", {facet_addr_out, vertex_addr_out, valid_out,
                            busy_out, obj_done_out, err_out}, 0);
        rst_in = 1'b0;

        run(0, 12, 0, 1'b1, 0);
        chk("v0_literal", first_tri[127:0],
            {32'h100, 32'h200, 32'h300, 32'h0001_0000});

        run(3, 2, 5, 1'b0, 0);

        run(10, 4, 0, 1'b0, 0);
        chk("wrap_count", 384'(hs_fa.size()), 4);
        foreach (wl[i])
            if (i < hs_fa.size()) chk("wrap_addr", 384'(hs_fa[i]), 384'(wl[i]));

        run(4, 0, 0, 1'b0, 0);

        fr[16] = 9;
        run(5, 1, 0, 1'b0, 0);
        chk("bad_v1_literal", first_tri[255:128], {96'h0, 32'h0001_0000});
        chk("err_set", 384'(err_out), 1);
        fr[16] = 5;
        run(0, 2, 0, 1'b0, 0);
        chk("err_sticky", 384'(err_out), 1);

        // Reset while the run is in FETCH_V1.
        expq.delete();
        @(posedge clk); #1;
        start_in = 1'b1;
        first_facet_in = 16'd0;
        facet_count_in = 16'd3;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        err_model = 1'b0;
        chk("midreset_tri", tri_out, 0);
        chk("midreset_flags", {facet_addr_out, vertex_addr_out, valid_out,
                               busy_out, obj_done_out, err_out}, 0);
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_reset", 384'(done_cnt), 384'(d0));
        chk("idle_after_reset", 384'(busy_out), 0);

        run(1, 2, 0, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tri_fetch_stream.md
Name: tri_fetch_stream

Overview:
- Parametrised triangle fetcher for the 3D pipeline.
- Walks a facet range of an indexed mesh: reads each facet's three vertex indices from a facet ROM, then each vertex's x/y/z from a vertex ROM.
- Emits one homogeneous triangle per facet on a ready/valid stream to the transform stage.
- ROMs sit outside the block, so one fetcher can serve any mesh, and ROM latency and widths are generic.

Parameters:
- NUM_FACETS, 12: facet ROM depth; facet addresses wrap modulo this value.
- NUM_VERTICES, 8: vertex ROM depth; vertex indices >= this are out of range.
- COORD_WIDTH, 32: width of each coordinate (x, y, z, w).
- IDX_WIDTH, 16: width of a vertex index and of facet addresses/counts.
- ROM_LATENCY, 2: cycles from address presented to data valid, for both ROMs (>=1).
- W_ONE, 32'h0001_0000: value driven on every w coordinate (1.0 in fixed point).

Ports:
- clk_in, in, 1: clock.
- rst_in, in, 1: synchronous active-high reset.
- start_in, in, 1: one-cycle pulse that begins a fetch run; ignored while busy_out=1.
- first_facet_in, in, IDX_WIDTH: first facet address; sampled on an accepted start.
- facet_count_in, in, IDX_WIDTH: number of facets to fetch; sampled on an accepted start.
- facet_addr_out, out, IDX_WIDTH: facet ROM address (registered).
- facet_data_in, in, 3*IDX_WIDTH: {f1,f2,f3}, with f1 in the MSBs.
- vertex_addr_out, out, IDX_WIDTH: vertex ROM address (registered).
- vertex_data_in, in, 3*COORD_WIDTH: {x,y,z}, with x in the MSBs.
- tri_out, out, 12*COORD_WIDTH: vertex v (0..2), coordinate c (3=x, 2=y, 1=z, 0=w) at bits [(4v+c)*COORD_WIDTH +: COORD_WIDTH].
- valid_out, out, 1: tri_out holds a triangle.
- ready_in, in, 1: downstream accepts when valid_out and ready_in are both 1.
- busy_out, out, 1: run in progress.
- obj_done_out, out, 1: one-cycle pulse at the end of a run.
- err_out, out, 1: sticky out-of-range vertex index flag.

Behaviour:
- Reset: all outputs 0 (addresses 0, tri_out 0); state IDLE; internal counters cleared. Applies mid-run: any held triangle is dropped and no obj_done pulse is produced.
- States: IDLE, FETCH_F, FETCH_V0, FETCH_V1, FETCH_V2, OUT.
- IDLE:
  - start_in=1 with facet_count_in>0: latch the range, set busy_out=1, set facet_addr_out=first_facet_in, enter FETCH_F.
  - start_in=1 with facet_count_in=0: obj_done_out pulses on the next cycle; busy_out stays 0.
- Fetch timing: an address is held stable from the cycle its state is entered (cycle t) through t+ROM_LATENCY. Data is sampled on the edge closing cycle t+ROM_LATENCY, so each fetch state lasts ROM_LATENCY+1 cycles. A wait counter runs from ROM_LATENCY down to 0.
- FETCH_F: latch f1/f2/f3; set vertex_addr_out=f1; go to FETCH_V0.
- FETCH_Vk (k=0..2):
  - Capture x, y, z into vertex k; set its w to W_ONE.
  - For k<2, set vertex_addr_out to the next index and go to FETCH_V(k+1).
  - For k=2, assert valid_out and go to OUT.
- Out-of-range index (>= NUM_VERTICES):
  - No ROM read is relied on; that vertex gets x=y=z=0, w=W_ONE.
  - err_out is set and stays set until rst_in.
  - The triangle is still emitted.
- OUT:
  - valid_out=1 and tri_out are held stable until ready_in=1.
  - On handshake with more facets remaining: valid_out drops the next cycle; facet_addr_out = (previous + 1) mod NUM_FACETS; go to FETCH_F.
  - On handshake of the last facet: obj_done_out pulses in the cycle after the handshake; busy_out drops the same cycle; go to IDLE.
- Throughput: 4*(ROM_LATENCY+1)+1 cycles per triangle with ready_in held high (13 at the default ROM_LATENCY). Each stall cycle of ready_in adds one cycle.
- Range wrap: first_facet_in+facet_count_in may exceed NUM_FACETS; addresses wrap to 0. facet_count_in > NUM_FACETS refetches facets; this is legal.
- start_in while busy_out=1: ignored, with no effect on the run in progress.
- No combinational path from ready_in to any output.

Test Plan:
- Cube mesh, L=2, start with first=0, count=12, ready held 1 -> 12 triangles, one every 13 cycles. Facet 0 = {0,1,2} yields vertex 0 = (x0,y0,z0,0x10000). obj_done pulses once, after the 12th handshake.
- Backpressure: ready low for 5 cycles during OUT -> valid_out and tri_out stay unchanged across all 5 cycles; the triangle is accepted exactly once; no facet is skipped or duplicated.
- Wrap: first=10, count=4 -> facet_addr_out sequence 10, 11, 0, 1; 4 triangles; then obj_done.
- Zero count: start with count=0 -> no valid_out; obj_done pulses 1 cycle later; busy_out stays 0.
- Bad index: facet {0,9,2} with NUM_VERTICES=8 -> vertex 1 = (0,0,0,0x10000); err_out goes 1 and stays 1 through the next start; the triangle is still output.
- Reset mid-run during FETCH_V1, then a second start pulse while busy in a new run -> after reset, all outputs are 0 with no obj_done pulse; the second pulse is ignored; the new run completes normally.
